// File: rtl/reduce_pkg.sv
// Shared types and elaboration-time helpers for the pipelined reduction tree.
package reduce_pkg;

   typedef enum logic [1:0] {
      RED_AND = 2'b00,
      RED_OR  = 2'b01,
      RED_XOR = 2'b10,
      RED_NOR = 2'b11
   } reduce_op_e;

   // Value that leaves a node result unchanged; NOR travels as OR so it pads with 0.
   function automatic logic red_identity(reduce_op_e op);
      return op == RED_AND;
   endfunction

   function automatic int red_levels(int width, int fanin);
      int n  = width;
      int lv = 0;
      for (int i = 0; i < 32; i++) begin
         if (n > 1) begin
            n  = (n + fanin - 1) / fanin;
            lv = lv + 1;
         end
      end
      return lv;
   endfunction

   function automatic int red_level_width(int width, int fanin, int k);
      int n = width;
      for (int i = 0; i < 32; i++) begin
         if (i <= k) n = (n + fanin - 1) / fanin;
      end
      return n;
   endfunction

endpackage

// File: rtl/pipelined_reduce_tree_if.sv
// Operand/result handshake bundle for pipelined_reduce_tree.
interface pipelined_reduce_tree_if
   import reduce_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int TAG_W = 5
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   reduce_op_e       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic             out_result;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_data, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );

endinterface

// File: rtl/reduce_node.sv
// One FANIN-input tree node; NOR is reduced as OR and inverted at the tree output.
module reduce_node
   import reduce_pkg::*;
#(
   parameter int FANIN = 4
) (
   input  logic [FANIN-1:0] din,
   input  reduce_op_e       op,
   output logic             dout
);

   always_comb begin
      dout = 1'b0;
      case (op)
         RED_AND: dout = &din;
         RED_XOR: dout = ^din;
         default: dout = |din;
      endcase
   end

endmodule

// File: rtl/pipelined_reduce_tree.sv
// FANIN-ary bit-reduction tree with a register after every level and a
// valid/ready handshake that collapses bubbles while the output is stalled.
module pipelined_reduce_tree
   import reduce_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int FANIN = 4,
   parameter int TAG_W = 5
) (
   input logic                    clk,
   input logic                    reset,
   input logic                    flush,
   pipelined_reduce_tree_if.slave bus
);

   localparam int LEVELS = red_levels(WIDTH, FANIN);

   logic [LEVELS-1:0] v_q;
   logic [LEVELS-1:0] en;

   // A stage may load when the output drains or any stage at or below it is empty.
   always_comb begin
      logic full_below;
      full_below = 1'b1;
      en         = '0;
      for (int k = LEVELS - 1; k >= 0; k--) begin
         full_below = full_below & v_q[k];
         en[k]      = bus.out_ready | ~full_below;
      end
   end

   assign bus.in_ready = en[0];

   for (genvar k = 0; k < LEVELS; k++) begin : lvl
      localparam int IN_W  = (k == 0) ? WIDTH : red_level_width(WIDTH, FANIN, k - 1);
      localparam int OUT_W = red_level_width(WIDTH, FANIN, k);
      localparam int PAD_W = OUT_W * FANIN;

      logic [IN_W-1:0]  src_data;
      reduce_op_e       src_op;
      logic [TAG_W-1:0] src_tag;
      logic             src_valid;
      logic [PAD_W-1:0] padded;
      logic [OUT_W-1:0] node_out;
      logic [OUT_W-1:0] next_data;
      logic [OUT_W-1:0] data_q;
      logic [TAG_W-1:0] tag_q;
      logic             valid_q;

      if (k == 0) begin : g_src
         assign src_data  = bus.in_data;
         assign src_op    = bus.in_op;
         assign src_tag   = bus.in_tag;
         assign src_valid = bus.in_valid;
      end else begin : g_src
         assign src_data  = lvl[k-1].data_q;
         assign src_op    = lvl[k-1].g_op.op_q;
         assign src_tag   = lvl[k-1].tag_q;
         assign src_valid = lvl[k-1].valid_q;
      end

      always_comb begin
         padded             = {PAD_W{red_identity(src_op)}};
         padded[IN_W-1:0]   = src_data;
      end

      for (genvar n = 0; n < OUT_W; n++) begin : g_node
         reduce_node #(.FANIN(FANIN)) u_node (
            .din  (padded[n*FANIN +: FANIN]),
            .op   (src_op),
            .dout (node_out[n])
         );
      end

      assign next_data = (k == LEVELS - 1 && src_op == RED_NOR) ? ~node_out : node_out;

      always_ff @(posedge clk) begin
         if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
         end else begin
            if (flush)      valid_q <= 1'b0;
            else if (en[k]) valid_q <= src_valid;
            if (en[k]) begin
               data_q <= next_data;
               tag_q  <= src_tag;
            end
         end
      end

      // The final stage has already applied the op, so it keeps no op register.
      if (k < LEVELS - 1) begin : g_op
         reduce_op_e op_q;
         always_ff @(posedge clk) begin
            if (reset)      op_q <= RED_AND;
            else if (en[k]) op_q <= src_op;
         end
      end

      assign v_q[k] = valid_q;
   end

   assign bus.out_valid  = v_q[LEVELS-1];
   assign bus.out_result = lvl[LEVELS-1].data_q[0];
   assign bus.out_tag    = lvl[LEVELS-1].tag_q;

endmodule

// File: tb/tb_pipelined_reduce_tree.sv
// Bench for pipelined_reduce_tree: default 64/4 instance plus a 10/4 instance,
// directed vectors with literal expectations and a queue-based scoreboard.
module tb_pipelined_reduce_tree;
   import reduce_pkg::*;

   localparam int W   = 64;
   localparam int F   = 4;
   localparam int TW  = 5;
   localparam int LV  = 3;
   localparam int SW  = 10;
   localparam int SLV = 2;

   logic clk = 1'b0;
   logic reset, flush, rst_s, flush_s;

   int vectors     = 0;
   int miscompares = 0;
   bit sb_on       = 1'b0;

   pipelined_reduce_tree_if #(.WIDTH(W),  .TAG_W(TW)) bus  ();
   pipelined_reduce_tree_if #(.WIDTH(SW), .TAG_W(TW)) sbus ();

   pipelined_reduce_tree #(.WIDTH(W), .FANIN(F), .TAG_W(TW)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   pipelined_reduce_tree #(.WIDTH(SW), .FANIN(F), .TAG_W(TW)) dut_s (
      .clk   (clk),
      .reset (rst_s),
      .flush (flush_s),
      .bus   (sbus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Flat reduction over the operand bits, no tree structure involved.
   function automatic logic model_reduce(logic [63:0] d, reduce_op_e op, int w);
      logic a = 1'b1, o = 1'b0, x = 1'b0;
      for (int i = 0; i < w; i++) begin
         a = a & d[i];
         o = o | d[i];
         x = x ^ d[i];
      end
      case (op)
         RED_AND: return a;
         RED_OR:  return o;
         RED_XOR: return x;
         default: return ~o;
      endcase
   endfunction

   typedef struct {
      logic          res;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t q[$];
   exp_t sq[$];

   always @(negedge clk) begin
      if (sb_on) begin
         check("in_ready", bus.in_ready, bus.out_ready || q.size() < LV);
         if (q.size() == 0) check("out_valid_idle", bus.out_valid, 1'b0);
         else if (bus.out_valid) begin
            check("sb_result", bus.out_result, q[0].res);
            check("sb_tag", bus.out_tag, q[0].tag);
         end
         if (reset || flush) q.delete();
         else begin
            if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
            if (bus.in_valid && bus.in_ready)
               q.push_back('{model_reduce(bus.in_data, bus.in_op, W), bus.in_tag});
         end

         check("s_in_ready", sbus.in_ready, sbus.out_ready || sq.size() < SLV);
         if (sq.size() == 0) check("s_out_valid_idle", sbus.out_valid, 1'b0);
         else if (sbus.out_valid) begin
            check("s_sb_result", sbus.out_result, sq[0].res);
            check("s_sb_tag", sbus.out_tag, sq[0].tag);
         end
         if (rst_s || flush_s) sq.delete();
         else begin
            if (sbus.out_valid && sbus.out_ready && sq.size() > 0) void'(sq.pop_front());
            if (sbus.in_valid && sbus.in_ready)
               sq.push_back('{model_reduce(64'(sbus.in_data), sbus.in_op, SW), sbus.in_tag});
         end
      end
   end

   task automatic run_one(input logic [W-1:0] d, input reduce_op_e op, input logic [TW-1:0] tag,
                          input logic exp, input string name);
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_op = op; bus.in_tag = tag;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 1; i <= LV; i++) begin
         if (i > 1) begin @(posedge clk); #1; end
         if (i < LV) check({name, "_early"}, bus.out_valid, 1'b0);
         else begin
            check({name, "_valid"}, bus.out_valid, 1'b1);
            check({name, "_result"}, bus.out_result, exp);
            check({name, "_tag"}, bus.out_tag, tag);
         end
      end
   endtask

   task automatic run_one_s(input logic [SW-1:0] d, input reduce_op_e op, input logic [TW-1:0] tag,
                            input logic exp, input string name);
      sbus.in_valid = 1'b1; sbus.in_data = d; sbus.in_op = op; sbus.in_tag = tag;
      @(posedge clk); #1;
      sbus.in_valid = 1'b0;
      for (int i = 1; i <= SLV; i++) begin
         if (i > 1) begin @(posedge clk); #1; end
         if (i < SLV) check({name, "_early"}, sbus.out_valid, 1'b0);
         else begin
            check({name, "_valid"}, sbus.out_valid, 1'b1);
            check({name, "_result"}, sbus.out_result, exp);
            check({name, "_tag"}, sbus.out_tag, tag);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] bd [4];
      reduce_op_e   bo [4];
      logic         be [4];
      bd = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 64'h0};
      bo = '{RED_AND, RED_OR, RED_XOR, RED_NOR};
      be = '{1'b1, 1'b0, 1'b1, 1'b1};

      reset = 1'b1; rst_s = 1'b1; flush = 1'b0; flush_s = 1'b0;
      bus.in_valid  = 1'b0; bus.in_data  = '0; bus.in_op  = RED_AND; bus.in_tag  = '0; bus.out_ready  = 1'b1;
      sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_op = RED_AND; sbus.in_tag = '0; sbus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; rst_s = 1'b0; sb_on = 1'b1;

      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_result", bus.out_result, 1'b0);
      check("rst_out_tag", bus.out_tag, 0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_s_out_valid", sbus.out_valid, 1'b0);
      @(posedge clk); #1;

      run_one(64'hFFFF_FFFF_FFFF_FFFF, RED_AND, 5'd5, 1'b1, "and_ones");
      run_one(64'hFFFF_FFDF_FFFF_FFFF, RED_AND, 5'd6, 1'b0, "and_bit37");
      run_one(64'h8000_0000_0000_0001, RED_XOR, 5'd7, 1'b0, "xor_two");
      run_one(64'h0000_0000_0000_0007, RED_XOR, 5'd8, 1'b1, "xor_three");
      run_one(64'h0, RED_NOR, 5'd9, 1'b1, "nor_zero");
      run_one(64'h10, RED_NOR, 5'd10, 1'b0, "nor_bit4");
      @(posedge clk); #1;

      // Back-to-back ops; txn j appears LV-1 edges after its accept edge.
      for (int i = 0; i <= LV + 2; i++) begin
         if (i < 4) begin
            bus.in_valid = 1'b1; bus.in_data = bd[i]; bus.in_op = bo[i]; bus.in_tag = TW'(i + 1);
         end else bus.in_valid = 1'b0;
         @(posedge clk); #1;
         if (i >= LV - 1) begin
            check("b2b_valid", bus.out_valid, 1'b1);
            check("b2b_result", bus.out_result, be[i-LV+1]);
            check("b2b_tag", bus.out_tag, i - LV + 2);
         end
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("b2b_done", bus.out_valid, 1'b0);

      // Stall: only LV operands fit.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1; bus.in_data = '1; bus.in_op = RED_AND; bus.in_tag = TW'(10 + i);
         @(negedge clk);
         check("stall_in_ready", bus.in_ready, i < LV);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < LV; i++) begin
         @(negedge clk);
         if (i == 0) check("drain_in_ready", bus.in_ready, 1'b1);
         check("drain_valid", bus.out_valid, 1'b1);
         check("drain_tag", bus.out_tag, 10 + i);
      end
      @(negedge clk);
      check("drain_done", bus.out_valid, 1'b0);
      @(posedge clk); #1;

      // Flush with two in flight and a third offered in the flush cycle.
      bus.in_valid = 1'b1; bus.in_data = '1; bus.in_op = RED_OR; bus.in_tag = 5'd20;
      @(posedge clk); #1;
      bus.in_tag = 5'd21;
      @(posedge clk); #1;
      bus.in_tag = 5'd22; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      for (int i = 0; i < LV + 2; i++) begin
         check("flush_quiet", bus.out_valid, 1'b0);
         @(posedge clk); #1;
      end
      run_one(64'h5, RED_XOR, 5'd23, 1'b0, "post_flush");
      @(posedge clk); #1;

      // Narrow instance: padding must not disturb any op.
      run_one_s(10'h3FF, RED_AND, 5'd1, 1'b1, "s_and_ones");
      run_one_s(10'h1FF, RED_AND, 5'd2, 1'b0, "s_and_msb0");
      run_one_s(10'h200, RED_OR,  5'd3, 1'b1, "s_or_msb");
      run_one_s(10'h3FF, RED_XOR, 5'd4, 1'b0, "s_xor_ten");
      run_one_s(10'h200, RED_XOR, 5'd5, 1'b1, "s_xor_one");
      run_one_s(10'h000, RED_NOR, 5'd6, 1'b1, "s_nor_zero");
      @(posedge clk); #1;

      // Reset lands on the edge where tag 7 would have reached the output.
      sbus.in_valid = 1'b1; sbus.in_data = 10'h3FF; sbus.in_op = RED_AND; sbus.in_tag = 5'd7;
      @(posedge clk); #1;
      sbus.in_tag = 5'd8; rst_s = 1'b1;
      @(posedge clk); #1;
      rst_s = 1'b0; sbus.in_valid = 1'b0;
      check("s_reset_valid", sbus.out_valid, 1'b0);
      check("s_reset_tag", sbus.out_tag, 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("s_reset_quiet", sbus.out_valid, 1'b0);
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
